mcs_di_bridge: RTL

MCS_DI_BRIDGE -- requirements
Module: mcs_di_bridge

---
 rtl/mcs_di_bridge.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mcs_di_bridge.sv
// -----------------------------------------------------------------------------
// mcs_di_bridge
// Bridges the MicroBlaze MCS IO bus onto a beat-oriented device interface.
// One MCS read or write becomes a device transaction of 1..4 beats (set by the
// device data width and the byte enables). Each beat is a single-cycle
// di_read/di_write pulse issued after the device signals ready. A per-wait
// timeout aborts a stalled transaction. Completion is a one-cycle IO_Ready
// pulse, with a 16-bit status returned on mcs_transfer_status.
//
// Ports
//   ifclk, resetb                     clock, async active-low reset
//   IO_*                              MCS IO bus (IO_Addr_Strobe is unused)
//   mcs_term_addr                     terminal address, captured per access
//   mcs_transfer_status               status of the last completed access
//   di_term_addr/di_reg_addr/di_len   transaction descriptor, held while busy
//   di_read_mode/di_read_req/di_read  read-side controls
//   di_read_rdy/di_reg_datao          read-side ready and data from device
//   di_write_mode/di_write            write-side controls
//   di_write_rdy/di_reg_datai         write-side ready and data to device
//   di_transfer_status                device status, sampled on each beat
//   busy                              high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module mcs_di_bridge #(
    parameter int unsigned DI_DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] TIMEOUT_STATUS = 16'hFFFF
) (
    input  logic                     ifclk,
    input  logic                     resetb,

    input  logic                     IO_Addr_Strobe,
    input  logic                     IO_Read_Strobe,
    input  logic                     IO_Write_Strobe,
    input  logic [31:0]              IO_Address,
    input  logic [3:0]               IO_Byte_Enable,
    input  logic [31:0]              IO_Write_Data,
    output logic [31:0]              IO_Read_Data,
    output logic                     IO_Ready,

    input  logic [15:0]              mcs_term_addr,
    output logic [15:0]              mcs_transfer_status,

    output logic [15:0]              di_term_addr,
    output logic [31:0]              di_reg_addr,
    output logic [31:0]              di_len,

    output logic                     di_read_mode,
    output logic                     di_read_req,
    output logic                     di_read,
    input  logic                     di_read_rdy,
    input  logic [DI_DATA_WIDTH-1:0] di_reg_datao,

    output logic                     di_write_mode,
    output logic                     di_write,
    input  logic                     di_write_rdy,
    output logic [DI_DATA_WIDTH-1:0] di_reg_datai,

    input  logic [15:0]              di_transfer_status,
    output logic                     busy
);

    localparam int unsigned BPB       = DI_DATA_WIDTH / 8;
    localparam int unsigned MAX_BEATS = 32 / DI_DATA_WIDTH;
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_WAIT,
        ST_DONE
    } state_e;

    // ---------------------------------------------------------------- state
    state_e                     state_q;
    logic [31:0]                rd_data_q;
    logic                       ready_q;
    logic [15:0]                status_q;
    logic [15:0]                sticky_q;
    logic [15:0]                term_q;
    logic [31:0]                reg_addr_q;
    logic [31:0]                len_q;
    logic [31:0]                wdata_q;
    logic [2:0]                 nb_q;
    logic [2:0]                 beat_idx_q;
    logic [15:0]                cnt_q;
    logic                       rd_mode_q;
    logic                       rd_req_q;
    logic                       rd_q;
    logic                       wr_mode_q;
    logic                       wr_q;
    logic [DI_DATA_WIDTH-1:0]   datai_q;
    logic                       busy_q;

    // ------------------------------------------------------ combinational
    logic [31:0]                len_c;
    logic [2:0]                 nb_c;
    logic [31:0]                len_mask_c;
    logic [31:0]                rd_merge_c;
    logic [DI_DATA_WIDTH-1:0]   wr_slice_c;
    logic [15:0]                status_new_c;
    logic                       last_beat_c;
    logic                       rdy_c;
    logic                       beat_c;
    logic                       unused_c;

    // Address bits outside the word index and the address strobe carry no meaning here
    assign unused_c = ^{IO_Addr_Strobe, IO_Address[31:30], IO_Address[1:0]};

    // Byte count and beat count of the access being accepted
    always_comb begin
        len_c = 32'd1;
        case (IO_Byte_Enable)
            4'hF:    len_c = 32'd4;
            4'h3:    len_c = 32'd2;
            default: len_c = 32'd1;
        endcase
        nb_c = 3'((len_c + 32'(BPB) - 32'd1) / 32'(BPB));
    end

    // Valid-byte mask for the captured length; bytes above it read as zero
    always_comb begin
        len_mask_c = 32'h0000_00FF;
        case (len_q)
            32'd4:   len_mask_c = 32'hFFFF_FFFF;
            32'd2:   len_mask_c = 32'h0000_FFFF;
            default: len_mask_c = 32'h0000_00FF;
        endcase
    end

    // Lane select for the current beat; beat 0 starts from a clean word so
    // stale data from an earlier access never leaks into the upper lanes
    always_comb begin
        rd_merge_c = (beat_idx_q == 3'd0) ? 32'd0 : rd_data_q;
        wr_slice_c = '0;
        for (int k = 0; k < int'(MAX_BEATS); k++) begin
            if (beat_idx_q == 3'(k)) begin
                rd_merge_c[k*DI_DATA_WIDTH +: DI_DATA_WIDTH] = di_reg_datao;
                wr_slice_c = wdata_q[k*DI_DATA_WIDTH +: DI_DATA_WIDTH];
            end
        end
        rd_merge_c = rd_merge_c & len_mask_c;
    end

    // First nonzero device status of the transaction wins
    assign status_new_c = (sticky_q != 16'd0) ? sticky_q : di_transfer_status;
    assign last_beat_c  = (beat_idx_q == (nb_q - 3'd1));
    assign rdy_c        = (state_q == ST_RD_WAIT) ? di_read_rdy : di_write_rdy;
    assign beat_c       = rd_q | wr_q;

    // --------------------------------------------------------------- FSM
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= ST_IDLE;
            rd_data_q  <= 32'd0;
            ready_q    <= 1'b0;
            status_q   <= 16'd0;
            sticky_q   <= 16'd0;
            term_q     <= 16'd0;
            reg_addr_q <= 32'd0;
            len_q      <= 32'd0;
            wdata_q    <= 32'd0;
            nb_q       <= 3'd0;
            beat_idx_q <= 3'd0;
            cnt_q      <= 16'd0;
            rd_mode_q  <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_q       <= 1'b0;
            wr_mode_q  <= 1'b0;
            wr_q       <= 1'b0;
            datai_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                // Accept an access; write wins when both strobes are high
                ST_IDLE: begin
                    if (IO_Write_Strobe || IO_Read_Strobe) begin
                        term_q     <= mcs_term_addr;
                        reg_addr_q <= {4'b0000, IO_Address[29:2]};
                        len_q      <= len_c;
                        wdata_q    <= IO_Write_Data;
                        nb_q       <= nb_c;
                        beat_idx_q <= 3'd0;
                        cnt_q      <= 16'd0;
                        sticky_q   <= 16'd0;
                        busy_q     <= 1'b1;
                        if (IO_Write_Strobe) begin
                            state_q   <= ST_WR_WAIT;
                            wr_mode_q <= 1'b1;
                        end else begin
                            state_q   <= ST_RD_REQ;
                            rd_mode_q <= 1'b1;
                            rd_req_q  <= 1'b1;
                        end
                    end
                end

                // Single-cycle read request to the device
                ST_RD_REQ: begin
                    rd_req_q <= 1'b0;
                    state_q  <= ST_RD_WAIT;
                end

                // Beat handshake shared by both directions
                ST_RD_WAIT, ST_WR_WAIT: begin
                    if (beat_c) begin
                        // The pulsing cycle is the beat: capture data and status
                        rd_q       <= 1'b0;
                        wr_q       <= 1'b0;
                        cnt_q      <= 16'd0;
                        beat_idx_q <= beat_idx_q + 3'd1;
                        sticky_q   <= status_new_c;
                        if (state_q == ST_RD_WAIT) begin
                            rd_data_q <= rd_merge_c;
                        end
                        if (last_beat_c) begin
                            state_q   <= ST_DONE;
                            ready_q   <= 1'b1;
                            status_q  <= status_new_c;
                            rd_mode_q <= 1'b0;
                            wr_mode_q <= 1'b0;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        // Stalled too long: abort without further beats
                        state_q   <= ST_DONE;
                        ready_q   <= 1'b1;
                        status_q  <= TIMEOUT_STATUS;
                        rd_mode_q <= 1'b0;
                        wr_mode_q <= 1'b0;
                        if (state_q == ST_RD_WAIT) begin
                            rd_data_q <= 32'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        if (rdy_c) begin
                            if (state_q == ST_RD_WAIT) begin
                                rd_q <= 1'b1;
                            end else begin
                                wr_q    <= 1'b1;
                                datai_q <= wr_slice_c;
                            end
                        end
                    end
                end

                // Completion pulse, then back to idle
                ST_DONE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------ outputs
    assign IO_Read_Data        = rd_data_q;
    assign IO_Ready            = ready_q;
    assign mcs_transfer_status = status_q;
    assign di_term_addr        = term_q;
    assign di_reg_addr         = reg_addr_q;
    assign di_len              = len_q;
    assign di_read_mode        = rd_mode_q;
    assign di_read_req         = rd_req_q;
    assign di_read             = rd_q;
    assign di_write_mode       = wr_mode_q;
    assign di_write            = wr_q;
    assign di_reg_datai        = datai_q;
    assign busy                = busy_q;

endmodule
